// File: rtl/vh_result_unpacker.sv
// Unpacks the 90-bit vloghammer result vector {y0..y17} into 18 extended field beats.
// Optional parity check of the packed word is enabled with `define VH_PARITY_CHECK_EN.
module vh_result_unpacker #(
    parameter int OUT_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [89:0]      in_word,
`ifdef VH_PARITY_CHECK_EN
    input  logic             in_parity,
    output logic             parity_err,
    output logic [CNT_W-1:0] err_count,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] field_data,
    output logic [4:0]       field_idx,
    output logic             field_signed,
    output logic             field_last,
    output logic [CNT_W-1:0] words_done
);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t      state;
    logic [89:0] hold;
    logic [4:0]  idx;

    logic        last_hs;
    logic        accept;

    logic [6:0]       lsb;
    logic [2:0]       wid;
    logic             sgn;
    logic [OUT_W-1:0] raw;
    logic [OUT_W-1:0] keep;
    logic [OUT_W-1:0] ext;

    function automatic int unsigned fld_w(input int unsigned m);
        return 4 + m;
    endfunction

    function automatic int unsigned fld_off(input int unsigned m);
        return (m == 0) ? 0 : ((m == 1) ? 4 : 9);
    endfunction

    assign out_valid = (state == STREAM);
    assign last_hs   = out_valid && out_ready && (idx == 5'd17);
    assign in_ready  = (state == IDLE) || last_hs;
    assign accept    = in_valid && in_ready;

    // Fields repeat in 15-bit groups of widths 4/5/6; bounds are constants per index.
    always_comb begin
        lsb = '0;
        wid = 3'd4;
        sgn = 1'b0;
        for (int unsigned k = 0; k < 18; k++) begin
            if (idx == 5'(k)) begin
                lsb = 7'(90 - (k / 3) * 15 - fld_off(k % 3) - fld_w(k % 3));
                wid = 3'(fld_w(k % 3));
                sgn = (k % 6) >= 3;
            end
        end
    end

    always_comb begin
        raw  = OUT_W'(hold >> lsb);
        keep = ~({OUT_W{1'b1}} << wid);
        ext  = (sgn && raw[wid - 3'd1]) ? (raw | ~keep) : (raw & keep);
    end

    assign field_data   = out_valid ? ext : '0;
    assign field_idx    = out_valid ? idx : '0;
    assign field_signed = out_valid & sgn;
    assign field_last   = out_valid & (idx == 5'd17);

`ifdef VH_PARITY_CHECK_EN
    logic hold_par;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            hold       <= '0;
            idx        <= '0;
            words_done <= '0;
`ifdef VH_PARITY_CHECK_EN
            hold_par   <= 1'b0;
            parity_err <= 1'b0;
            err_count  <= '0;
`endif
        end else begin
`ifdef VH_PARITY_CHECK_EN
            parity_err <= 1'b0;
            if (last_hs && ((^hold) != hold_par)) begin
                parity_err <= 1'b1;
                err_count  <= err_count + 1'b1;
            end
            if (accept)
                hold_par <= in_parity;
`endif
            case (state)
                IDLE: begin
                    if (accept) begin
                        hold  <= in_word;
                        idx   <= '0;
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        if (idx == 5'd17) begin
                            words_done <= words_done + 1'b1;
                            if (accept) begin
                                hold <= in_word;
                                idx  <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            idx <= idx + 5'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vh_result_unpacker.sv
// Self-checking bench for vh_result_unpacker: hand tables, corner sequences and random words.
// Parity checks are compiled in with `define VH_PARITY_CHECK_EN.
module tb_vh_result_unpacker;

    localparam int OUT_W = 8;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [89:0]      in_word = '0;
    logic             in_parity = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [OUT_W-1:0] field_data;
    logic [4:0]       field_idx;
    logic             field_signed;
    logic             field_last;
    logic [CNT_W-1:0] words_done;
`ifdef VH_PARITY_CHECK_EN
    logic             parity_err;
    logic [CNT_W-1:0] err_count;
    int               exp_errs = 0;
`endif

    vh_result_unpacker #(.OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_word      (in_word),
`ifdef VH_PARITY_CHECK_EN
        .in_parity    (in_parity),
        .parity_err   (parity_err),
        .err_count    (err_count),
`endif
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .field_data   (field_data),
        .field_idx    (field_idx),
        .field_signed (field_signed),
        .field_last   (field_last),
        .words_done   (words_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_done = 0;

    logic [OUT_W-1:0] got_data [18];
    logic             got_sgn  [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: walk field widths from bit 89 down, then extend numerically.
    function automatic logic [OUT_W-1:0] model(input logic [89:0] w, input int k, output bit s);
        int widths [3] = '{4, 5, 6};
        int pos = 89;
        int width;
        int v = 0;
        for (int j = 0; j < k; j++) pos -= widths[j % 3];
        width = widths[k % 3];
        for (int b = 0; b < width; b++) v = v * 2 + int'(w[pos - b]);
        s = (k % 6) >= 3;
        if (s && v >= (1 << (width - 1))) v -= (1 << width);
        return OUT_W'(v);
    endfunction

    task automatic send(input logic [89:0] w, input bit par);
        int cyc = 0;
        in_valid  = 1'b1;
        in_word   = w;
        in_parity = par;
        #1;
        while (!in_ready && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!in_ready) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: in_ready stuck at 0");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Streams one word; stall_pct randomises out_ready, stall_at forces 5 stall cycles,
    // abort_at asserts reset at that beat, b2b presents w_next at the final handshake.
    task automatic stream(input logic [89:0] w, input bit par, input int stall_pct,
                          input int stall_at, input int abort_at,
                          input bit b2b, input logic [89:0] w_next);
        int k = 0;
        int cyc = 0;
        int stalled = 0;
        bit s;
        logic [OUT_W-1:0] e;
        while (k < 18 && cyc < 200) begin
            cyc++;
            if (k == stall_at && stalled < 5) begin
                out_ready = 1'b0;
                stalled++;
            end else begin
                out_ready = ($urandom_range(99) >= stall_pct);
            end
            if (b2b && k == 17 && out_ready) begin
                in_valid  = 1'b1;
                in_word   = w_next;
                in_parity = ^w_next;
            end
            #1;
            if (!out_valid) begin
                n_checks++; n_fail++;
                $display("FAIL out_valid: got 0 expected 1 at beat %0d", k);
                return;
            end
            e = model(w, k, s);
            chk("field_idx", 32'(field_idx), 32'(k));
            chk("field_data", 32'(field_data), 32'(e));
            chk("field_signed", 32'(field_signed), 32'(s));
            chk("field_last", 32'(field_last), 32'(k == 17));
            chk("in_ready_stream", 32'(in_ready), 32'(k == 17 && out_ready));
            if (k == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_out_valid", 32'(out_valid), 0);
                chk("rst_field_data", 32'(field_data), 0);
                chk("rst_field_idx", 32'(field_idx), 0);
                chk("rst_field_signed", 32'(field_signed), 0);
                chk("rst_field_last", 32'(field_last), 0);
                chk("rst_in_ready", 32'(in_ready), 1);
                chk("rst_words_done", 32'(words_done), 0);
                exp_done = 0;
`ifdef VH_PARITY_CHECK_EN
                exp_errs = 0;
`endif
                @(negedge clk);
                rst_n = 1'b1;
                @(posedge clk); #1;
                out_ready = 1'b1;
                return;
            end
            if (out_ready) begin
                got_data[k] = field_data;
                got_sgn[k]  = field_signed;
                k++;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        if (k < 18) begin
            n_checks++; n_fail++;
            $display("FAIL stream_timeout: got %0d beats expected 18", k);
            return;
        end
        exp_done++;
        chk("words_done", 32'(words_done), 32'(exp_done));
`ifdef VH_PARITY_CHECK_EN
        if ((^w) != par) exp_errs++;
        chk("parity_err", 32'(parity_err), 32'((^w) != par));
        chk("err_count", 32'(err_count), 32'(exp_errs));
`endif
    endtask

    typedef struct {
        logic [89:0]      word;
        int               idx;
        logic [OUT_W-1:0] data;
        bit               sgn;
    } vec_t;

    vec_t vecs [$];

    initial begin
        logic [89:0] ones;
        logic [89:0] y5;
        logic [89:0] w1;
        logic [89:0] w2;
        logic [95:0] r;

        ones = '1;
        y5   = 90'(6'b100000) << 60;
        vecs.push_back('{ones, 0,  8'h0F, 1'b0});
        vecs.push_back('{ones, 2,  8'h3F, 1'b0});
        vecs.push_back('{ones, 3,  8'hFF, 1'b1});
        vecs.push_back('{ones, 5,  8'hFF, 1'b1});
        vecs.push_back('{ones, 17, 8'hFF, 1'b1});
        vecs.push_back('{y5,   5,  8'hE0, 1'b1});
        vecs.push_back('{y5,   4,  8'h00, 1'b1});
        vecs.push_back('{y5,   6,  8'h00, 1'b0});
        vecs.push_back('{y5,   0,  8'h00, 1'b0});

        #12;
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_in_ready", 32'(in_ready), 1);
        chk("reset_field_data", 32'(field_data), 0);
        chk("reset_words_done", 32'(words_done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            send(vecs[i].word, ^vecs[i].word);
            stream(vecs[i].word, ^vecs[i].word, 0, -1, -1, 1'b0, '0);
            chk($sformatf("vec%0d_data", i), 32'(got_data[vecs[i].idx]), 32'(vecs[i].data));
            chk($sformatf("vec%0d_signed", i), 32'(got_sgn[vecs[i].idx]), 32'(vecs[i].sgn));
        end

        // Stall five cycles on beat 7.
        r = {$urandom(), $urandom(), $urandom()};
        w1 = r[89:0];
        send(w1, ^w1);
        stream(w1, ^w1, 0, 7, -1, 1'b0, '0);

        // Back-to-back words with no bubble.
        r = {$urandom(), $urandom(), $urandom()};
        w2 = r[89:0];
        exp_done = 0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(w1, ^w1);
        stream(w1, ^w1, 0, -1, -1, 1'b1, w2);
        stream(w2, ^w2, 0, -1, -1, 1'b0, '0);
        chk("b2b_words_done", 32'(words_done), 2);

        // Reset in mid-word, then a clean word.
        send(w2, ^w2);
        stream(w2, ^w2, 0, -1, 9, 1'b0, '0);
        send(w1, ^w1);
        stream(w1, ^w1, 0, -1, -1, 1'b0, '0);
        chk("post_reset_words_done", 32'(words_done), 1);

`ifdef VH_PARITY_CHECK_EN
        send(ones, 1'b1);
        stream(ones, 1'b1, 0, -1, -1, 1'b0, '0);
        @(posedge clk); #1;
        chk("parity_err_pulse_end", 32'(parity_err), 0);
        send(ones, 1'b0);
        stream(ones, 1'b0, 0, -1, -1, 1'b0, '0);
`endif

        // Random words with random backpressure and idle gaps.
        for (int n = 0; n < 20; n++) begin
            r = {$urandom(), $urandom(), $urandom()};
            w1 = r[89:0];
            r = {$urandom(), $urandom(), $urandom()};
            w2 = r[89:0];
            repeat ($urandom_range(2)) @(posedge clk);
            #1;
            send(w1, ^w1);
            if (n % 3 == 0) begin
                stream(w1, ^w1, 0, -1, -1, 1'b1, w2);
                stream(w2, ^w2, 30, -1, -1, 1'b0, '0);
            end else begin
                stream(w1, ^w1, 30, -1, -1, 1'b0, '0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
